// File: rtl/branch_resolve_unit.sv
// Zero-test branch resolver (BEQZ/BNEZ/BLTZ/BGEZ) with registered EX/MEM outcome and statistics.
// Define BRU_BHT_EN to build the 2-bit bimodal branch history table; otherwise fetch predicts not-taken.
module branch_resolve_unit #(
  parameter int WIDTH  = 16,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 16,
  parameter int PC_INC = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             kill,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic [WIDTH-1:0] ex_rs_val,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             fetch_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [PC_W-1:0]  res_redirect_pc,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredict
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  logic            is_br;
  logic            br_taken;
  logic            accept;
  logic            mispredict;
  logic            update;
  logic [PC_W-1:0] redirect_pc;
  logic            unused_fetch;

  always_comb begin
    is_br    = 1'b0;
    br_taken = 1'b0;
    case (ex_opcode)
      OP_BEQZ: begin
        is_br    = 1'b1;
        br_taken = (ex_rs_val == '0);
      end
      OP_BNEZ: begin
        is_br    = 1'b1;
        br_taken = (ex_rs_val != '0);
      end
      OP_BLTZ: begin
        is_br    = 1'b1;
        br_taken = ex_rs_val[WIDTH-1];
      end
      OP_BGEZ: begin
        is_br    = 1'b1;
        br_taken = ~ex_rs_val[WIDTH-1];
      end
      default: ;
    endcase
  end

  assign accept      = ex_valid & is_br;
  assign mispredict  = accept & (br_taken != ex_pred_taken);
  assign update      = accept & ~kill & ~stall;
  assign redirect_pc = br_taken ? ex_target : ex_pc + PC_W'(PC_INC);

  // Kill squashes the flags but leaves the redirect PC untouched; it is only meaningful with res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid       <= 1'b0;
      res_taken       <= 1'b0;
      res_mispredict  <= 1'b0;
      res_redirect_pc <= '0;
    end else if (kill) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
    end else if (!stall) begin
      res_valid       <= accept;
      res_taken       <= accept & br_taken;
      res_mispredict  <= mispredict;
      res_redirect_pc <= redirect_pc;
    end
  end

  // Counters saturate at all-ones; a clear overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches   <= '0;
      stat_mispredict <= '0;
    end else if (clr_stats) begin
      stat_branches   <= '0;
      stat_mispredict <= '0;
    end else if (update) begin
      if (stat_branches != '1) begin
        stat_branches <= stat_branches + CNT_W'(1);
      end
      if (mispredict && stat_mispredict != '1) begin
        stat_mispredict <= stat_mispredict + CNT_W'(1);
      end
    end
  end

  assign unused_fetch = ^fetch_pc;

`ifdef BRU_BHT_EN
  logic [1:0]       bht [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = ex_pc[IDX_W:1];
  assign rd_idx = fetch_pc[IDX_W:1];

  // Fetch reads the pre-update entry; there is deliberately no write-to-read bypass.
  assign fetch_pred_taken = bht[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (update) begin
      if (br_taken && bht[wr_idx] != 2'b11) begin
        bht[wr_idx] <= bht[wr_idx] + 2'b01;
      end else if (!br_taken && bht[wr_idx] != 2'b00) begin
        bht[wr_idx] <= bht[wr_idx] - 2'b01;
      end
    end
  end
`else
  assign fetch_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised self-checking bench for branch_resolve_unit against a spec-level model.
// Honours BRU_BHT_EN for the table-dependent prediction checks.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, kill, ex_valid, ex_pred_taken, clr_stats;
  logic [4:0]  ex_opcode;
  logic [15:0] ex_rs_val, ex_pc, ex_target, fetch_pc;
  logic        fetch_pred_taken, res_valid, res_taken, res_mispredict;
  logic [15:0] res_redirect_pc, stat_branches, stat_mispredict;
  logic        fpred2, valid2, taken2, mis2;
  logic [15:0] redir2;
  logic [1:0]  sbr2, smis2;

  int tests = 0;
  int errors = 0;
  bit check_en = 0;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .kill(kill), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rs_val(ex_rs_val), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_redirect_pc(res_redirect_pc), .clr_stats(clr_stats),
    .stat_branches(stat_branches), .stat_mispredict(stat_mispredict)
  );

  branch_resolve_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .kill(kill), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rs_val(ex_rs_val), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .fetch_pc(fetch_pc), .fetch_pred_taken(fpred2),
    .res_valid(valid2), .res_taken(taken2), .res_mispredict(mis2),
    .res_redirect_pc(redir2), .clr_stats(clr_stats),
    .stat_branches(sbr2), .stat_mispredict(smis2)
  );

  always #5 clk = ~clk;

  // Reference state, expressed directly in terms of branch outcomes and counts.
  int exp_valid, exp_taken, exp_mis, exp_redir;
  int exp_br, exp_misc, exp_br2, exp_misc2;
  int bht_m [16];

  task automatic checkOutput(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid = 0; exp_taken = 0; exp_mis = 0; exp_redir = 0;
      exp_br = 0; exp_misc = 0; exp_br2 = 0; exp_misc2 = 0;
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
    end else begin
      automatic int op = ex_opcode;
      automatic bit is_br = (op >= 12 && op <= 15);
      automatic bit tk = 0;
      automatic bit acc;
      automatic bit mp;
      automatic int idx = (ex_pc / 2) % 16;
      if (op == 12) tk = (ex_rs_val == 0);
      if (op == 13) tk = (ex_rs_val != 0);
      if (op == 14) tk = (ex_rs_val >= 16'h8000);
      if (op == 15) tk = (ex_rs_val < 16'h8000);
      acc = ex_valid && is_br;
      mp = acc && (tk != ex_pred_taken);
      if (kill) begin
        exp_valid = 0; exp_taken = 0; exp_mis = 0;
      end else if (!stall) begin
        exp_valid = acc;
        exp_taken = acc && tk;
        exp_mis = mp;
        if (acc) exp_redir = tk ? int'(ex_target) : (int'(ex_pc) + 2) % 65536;
      end
      if (clr_stats) begin
        exp_br = 0; exp_misc = 0; exp_br2 = 0; exp_misc2 = 0;
      end else if (acc && !kill && !stall) begin
        exp_br = (exp_br < 65535) ? exp_br + 1 : 65535;
        exp_br2 = (exp_br2 < 3) ? exp_br2 + 1 : 3;
        if (mp) begin
          exp_misc = (exp_misc < 65535) ? exp_misc + 1 : 65535;
          exp_misc2 = (exp_misc2 < 3) ? exp_misc2 + 1 : 3;
        end
      end
      if (acc && !kill && !stall) begin
        if (tk && bht_m[idx] < 3) bht_m[idx] = bht_m[idx] + 1;
        else if (!tk && bht_m[idx] > 0) bht_m[idx] = bht_m[idx] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      checkOutput("res_valid", res_valid, exp_valid);
      checkOutput("res_taken", res_taken, exp_taken);
      checkOutput("res_mispredict", res_mispredict, exp_mis);
      if (exp_valid != 0) checkOutput("res_redirect_pc", res_redirect_pc, exp_redir);
      checkOutput("stat_branches", stat_branches, exp_br);
      checkOutput("stat_mispredict", stat_mispredict, exp_misc);
      checkOutput("stat_branches_w2", sbr2, exp_br2);
      checkOutput("stat_mispredict_w2", smis2, exp_misc2);
      checkOutput("res_valid_w2", valid2, exp_valid);
`ifdef BRU_BHT_EN
      checkOutput("fetch_pred_taken", fetch_pred_taken, bht_m[(fetch_pc / 2) % 16] / 2);
`else
      checkOutput("fetch_pred_taken", fetch_pred_taken, 0);
`endif
    end
  end

  task automatic applyStimulus(input logic [4:0] op, input logic [15:0] rs, input logic [15:0] pc,
                               input logic [15:0] tgt, input bit pred, input bit v,
                               input bit st, input bit kl, input bit clr, input logic [15:0] fpc);
    ex_opcode = op; ex_rs_val = rs; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    ex_valid = v; stall = st; kill = kl; clr_stats = clr; fetch_pc = fpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, res_valid, 0);
    checkOutput({tag, "_taken"}, res_taken, 0);
    checkOutput({tag, "_mispredict"}, res_mispredict, 0);
    checkOutput({tag, "_redirect"}, res_redirect_pc, 0);
    checkOutput({tag, "_branches"}, stat_branches, 0);
    checkOutput({tag, "_mispredicts"}, stat_mispredict, 0);
    checkOutput({tag, "_branches_w2"}, sbr2, 0);
    checkOutput({tag, "_fetch_pred"}, fetch_pred_taken, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(5'd0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkAllZero("reset");
    check_en = 1;

    // BEQZ taken against a not-taken prediction
    applyStimulus(5'b01100, 16'h0000, 16'h0010, 16'h0040, 0, 1, 0, 0, 0, 16'h0010);
    tick();
    checkOutput("t1_valid", res_valid, 1);
    checkOutput("t1_taken", res_taken, 1);
    checkOutput("t1_mis", res_mispredict, 1);
    checkOutput("t1_redir", res_redirect_pc, 16'h0040);

    applyStimulus(5'b01110, 16'h8000, 16'h0020, 16'h0080, 1, 1, 0, 0, 0, 16'h0020);
    tick();
    checkOutput("t2_bltz_taken", res_taken, 1);
    checkOutput("t2_bltz_mis", res_mispredict, 0);
    checkOutput("t2_bltz_redir", res_redirect_pc, 16'h0080);

    // Fall-through from the top of the address space wraps to zero
    applyStimulus(5'b01111, 16'h8000, 16'hFFFE, 16'h1234, 1, 1, 0, 0, 0, 16'h0);
    tick();
    checkOutput("t2_bgez_taken", res_taken, 0);
    checkOutput("t2_bgez_mis", res_mispredict, 1);
    checkOutput("t2_bgez_redir", res_redirect_pc, 16'h0000);
    checkOutput("t2_branches", stat_branches, 3);
    checkOutput("t2_mispredicts", stat_mispredict, 2);

    applyStimulus(5'b01101, 16'h0005, 16'h0030, 16'h0060, 0, 1, 1, 0, 0, 16'h0);
    repeat (2) tick();
    checkOutput("t4_stall_valid", res_valid, 1);
    checkOutput("t4_stall_mis", res_mispredict, 1);
    checkOutput("t4_stall_redir", res_redirect_pc, 16'h0000);
    checkOutput("t4_stall_branches", stat_branches, 3);
    kill = 1;
    tick();
    checkOutput("t4_kill_valid", res_valid, 0);
    checkOutput("t4_kill_mis", res_mispredict, 0);
    checkOutput("t4_kill_branches", stat_branches, 3);
    checkOutput("t4_kill_mispredicts", stat_mispredict, 2);

    applyStimulus(5'b00000, 16'h0000, 16'h0040, 16'h0070, 0, 1, 0, 0, 0, 16'h0);
    tick();
    checkOutput("t5_nonbranch_valid", res_valid, 0);
    checkOutput("t5_nonbranch_branches", stat_branches, 3);

    applyStimulus(5'b01100, 16'h0001, 16'h0050, 16'h0090, 1, 1, 0, 0, 1, 16'h0);
    tick();
    checkOutput("t5_clr_valid", res_valid, 1);
    checkOutput("t5_clr_mis", res_mispredict, 1);
    checkOutput("t5_clr_redir", res_redirect_pc, 16'h0052);
    checkOutput("t5_clr_branches", stat_branches, 0);
    checkOutput("t5_clr_mispredicts", stat_mispredict, 0);

    applyStimulus(5'b01100, 16'h0000, 16'h0060, 16'h0100, 1, 1, 0, 0, 0, 16'h0);
    repeat (5) tick();
    checkOutput("t6_branches", stat_branches, 5);
    checkOutput("t6_branches_w2", sbr2, 3);
    checkOutput("t6_mispredicts_w2", smis2, 0);

`ifdef BRU_BHT_EN
    applyStimulus(5'b01101, 16'h0001, 16'h0004, 16'h0200, 0, 1, 0, 0, 0, 16'h0004);
    checkOutput("t3_pred_before", fetch_pred_taken, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3_pred_taken", fetch_pred_taken, 1);
    end
    ex_rs_val = 16'h0000;
    tick();
    checkOutput("t3_pred_nt1", fetch_pred_taken, 1);
    tick();
    checkOutput("t3_pred_nt2", fetch_pred_taken, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      automatic int r = $urandom_range(0, 3);
      automatic logic [15:0] rs;
      automatic logic [4:0] op;
      automatic bit st = ($urandom_range(0, 7) == 0);
      automatic bit kl = ($urandom_range(0, 15) == 0);
      automatic bit clr = ($urandom_range(0, 63) == 0);
      rs = (r == 0) ? 16'h0000 : (r == 1) ? 16'h8000 : 16'($urandom);
      op = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      if (clr) begin
        st = 0;
        kl = 0;
      end
      if (i == 1500) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        check_en = 0;
        #1;
        checkAllZero("async_rst");
        tick();
        rst_n = 1'b1;
        check_en = 1;
      end
      applyStimulus(op, rs, 16'($urandom) & 16'hFFFE, 16'($urandom) & 16'hFFFE,
                    1'($urandom), ($urandom_range(0, 5) != 0), st, kl, clr,
                    16'($urandom) & 16'hFFFE);
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
